// File: rtl/icache_ctrl.sv
// ============================================================================
// Module   : icache_ctrl
// Purpose  : Direct-mapped, read-only instruction cache with word-by-word
//            line refill over a req/valid memory port and a full flush.
//            Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        flush,
    output logic [31:0] InstrF,
    output logic        Mem_Stall,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF  = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = 32 - OFF - IDX - 2;
    localparam logic [OFF-1:0] LAST_WORD = OFF'(LINE_WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [OFF-1:0]         cnt_q, cnt_d;
    logic [31:0]            base_q, base_d;
    logic [IDX-1:0]         idx_q, idx_d;
    logic                   pend_q, pend_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;

    logic [31:0]            data_q [NUM_LINES][LINE_WORDS];
    logic [TAGW-1:0]        tag_q  [NUM_LINES];

    logic [OFF-1:0]         pc_word;
    logic [IDX-1:0]         pc_idx;
    logic [TAGW-1:0]        pc_tag;
    logic                   hit;
    logic                   refill_we;
    logic                   line_done;
    logic                   unused_pc_bits;

    assign pc_word        = PCF[OFF+1:2];
    assign pc_idx         = PCF[OFF+IDX+1:OFF+2];
    assign pc_tag         = PCF[31:OFF+IDX+2];
    assign hit            = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign unused_pc_bits = ^PCF[1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        valid_d     = valid_q;
        refill_we   = 1'b0;
        line_done   = 1'b0;
        InstrF      = '0;
        Mem_Stall   = 1'b0;
        mem_rd_req  = 1'b0;
        mem_rd_addr = base_q + {{(30-OFF){1'b0}}, cnt_q, 2'b00};

        case (state_q)
            S_IDLE: begin
                InstrF    = data_q[pc_idx][pc_word];
                Mem_Stall = !hit;
                if (flush) begin
                    valid_d = '0;
                end
                if (!hit) begin
                    state_d = S_REFILL;
                    base_d  = {PCF[31:OFF+2], {(OFF+2){1'b0}}};
                    idx_d   = pc_idx;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            S_REFILL: begin
                Mem_Stall  = 1'b1;
                mem_rd_req = 1'b1;
                // A flush seen anywhere in the refill suppresses validation of this line.
                if (flush) begin
                    valid_d = '0;
                    pend_d  = 1'b1;
                end
                if (mem_rd_valid) begin
                    refill_we = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        line_done = 1'b1;
                        state_d   = S_IDLE;
                        if (!flush && !pend_q) begin
                            valid_d[idx_q] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!rst) begin
            InstrF    = '0;
            Mem_Stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    // Storage arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            data_q[idx_q][cnt_q] <= mem_rd_data;
        end
        if (line_done) begin
            tag_q[idx_q] <= base_q[31:OFF+IDX+2];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (!hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

`default_nettype wire
